interrupt_priority_controller: RTL

//  Collects NUM_IRQ external interrupt lines, latches rising edges as pending requests and picks the

---
 rtl/interrupt_priority_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/interrupt_priority_controller.sv
// ---------------------------------------------------------------------------
// interrupt_priority_controller
//
// Purpose:
//   Turns rising edges on NUM_IRQ interrupt lines into pending requests, picks
//   the highest-priority unmasked one (index 0 is highest), and sequences one
//   interrupt entry at a time:
//     - a one-cycle int_pulse,
//     - a two-cycle entry window,
//     - a service phase that ends when the RET opcode reaches decode.
//   Interrupts do not nest.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   irq        level interrupt lines; a rising edge raises a request
//   irq_mask   per-source mask (1 = keep the request pending but do not issue it)
//   irq_en     global enable; gates new issues only
//   op         opcode at decode, watched for RET_OP during service
//   int_pulse  one-cycle strobe to jump control on issue
//   vec_addr   vector address of the issued source (held until the next issue)
//   int_id     index of the issued source (held until the next issue)
//   int_busy   high from issue through the end of service
//   pending    current pending-request register
// ---------------------------------------------------------------------------
module interrupt_priority_controller #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [15:0] VEC_BASE   = 16'hF000,
  parameter logic [15:0] VEC_STRIDE = 16'h0010,
  parameter logic [5:0]  RET_OP     = 6'b010000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               irq_en,
  input  logic [5:0]         op,
  output logic               int_pulse,
  output logic [15:0]        vec_addr,
  output logic [2:0]         int_id,
  output logic               int_busy,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    ENTRY   = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic               cnt_q, cnt_d;
  logic               int_pulse_q, int_pulse_d;
  logic [15:0]        vec_addr_q, vec_addr_d;
  logic [2:0]         int_id_q, int_id_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clear;
  logic [2:0]         winner;
  logic [15:0]        vec_calc;

  assign rise     = irq & ~irq_q;
  assign eligible = pending_q & ~irq_mask;

  // Lowest set index wins. The loop scans downward, so a lower index
  // overwrites any higher one found earlier in the scan.
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // The multiply is done at 16 bits, so the vector address wraps modulo 2^16.
  assign vec_calc = VEC_BASE + ({13'd0, winner} * VEC_STRIDE);

  // Next-state logic for the entry sequencer.
  // A new edge on the bit being issued in this same cycle re-sets that bit,
  // so the second request is not lost.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    int_pulse_d = 1'b0;
    vec_addr_d  = vec_addr_q;
    int_id_d    = int_id_q;
    clear       = '0;

    case (state_q)
      IDLE: begin
        if (irq_en && (|eligible)) begin
          state_d     = ISSUE;
          int_pulse_d = 1'b1;
          int_id_d    = winner;
          vec_addr_d  = vec_calc;
          for (int i = 0; i < NUM_IRQ; i++) begin
            clear[i] = (winner == 3'(i));
          end
        end
      end
      ISSUE: begin
        state_d = ENTRY;
        cnt_d   = 1'b0;
      end
      // The jump-control interrupt delay: op is deliberately ignored here.
      ENTRY: begin
        if (cnt_q) state_d = SERVICE;
        else       cnt_d   = 1'b1;
      end
      SERVICE: begin
        if (op == RET_OP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q & ~clear) | rise;
  end

  // State registers. Reset drops any interrupt in flight along with every
  // pending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      irq_q       <= '0;
      cnt_q       <= 1'b0;
      int_pulse_q <= 1'b0;
      vec_addr_q  <= 16'h0000;
      int_id_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      irq_q       <= irq;
      cnt_q       <= cnt_d;
      int_pulse_q <= int_pulse_d;
      vec_addr_q  <= vec_addr_d;
      int_id_q    <= int_id_d;
    end
  end

  assign int_pulse = int_pulse_q;
  assign vec_addr  = vec_addr_q;
  assign int_id    = int_id_q;
  assign int_busy  = (state_q != IDLE);
  assign pending   = pending_q;

endmodule
